// File: rtl/prescaled_updown_counter.sv
// prescaled_updown_counter
// Second-generation prescaled event counter: a run-time prescale divider
// feeds an up/down counter with a programmable limit, three terminal modes
// (wrap, saturate, one-shot), an IDLE/RUN/DONE state machine and a parallel
// load.
//
// Optional feature, enabled by defining PRESCALED_COUNTER_CAPTURE_EN:
// adds a capture strobe that snapshots the pre-step count into capture_val
// and pulses capture_vld for one cycle. It is independent of the state
// machine and never disturbs counting.
//
// Reset is synchronous and active-high (reset), on clk.

module prescaled_updown_counter #(
  parameter int N  = 32,  // count / limit / load width, N >= 2
  parameter int PW = 16   // prescale divider width, PW >= 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [PW-1:0] div,
  input  logic [N-1:0]  limit,
  input  logic          up,
  input  logic [1:0]    mode,
  input  logic          start,
  input  logic          stop,
  input  logic          load,
  input  logic [N-1:0]  load_val,
`ifdef PRESCALED_COUNTER_CAPTURE_EN
  input  logic          capture,
  output logic [N-1:0]  capture_val,
  output logic          capture_vld,
`endif
  output logic [N-1:0]  count,
  output logic          tick,
  output logic          tc,
  output logic          running,
  output logic          done
);

  // State encoding kept as plain constants so older tooling and scripts
  // that grep for numeric state values keep working.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Terminal modes; the reserved code 2'b11 falls through to wrap.
  localparam logic [1:0] MODE_WRAP    = 2'd0;
  localparam logic [1:0] MODE_SAT     = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;

  localparam logic [N-1:0]  CNT_ONE   = N'(1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);

  // Architectural state and its next-state values.
  logic [1:0]    state_q, state_d;
  logic [N-1:0]  count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q,  tick_d;
  logic          tc_q,    tc_d;

  // Derived per-cycle values.
  logic [N-1:0]  term_val;
  logic [N-1:0]  start_val;
  logic          at_term;
  logic          presc_match;
  logic [N-1:0]  step_val;
  logic          step_tc;
  logic          step_done;

  // Terminal and start values depend only on direction and limit.
  always_comb begin
    term_val    = up ? limit : '0;
    start_val   = up ? '0    : limit;
    at_term     = (count_q == term_val);
    presc_match = (presc_q == div);
  end

  // Value the count would take if a step happens this cycle, plus the
  // terminal-count and one-shot-completion flags that go with that step.
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so
    // no path leaves it unassigned; otherwise synthesis infers a latch.
    step_val  = count_q;
    step_tc   = 1'b0;
    step_done = 1'b0;

    if (!at_term) begin
      // Modulo-2^N arithmetic: a count loaded past limit runs through the
      // top of the range, wraps to 0 and then climbs to limit.
      step_val = up ? (count_q + CNT_ONE) : (count_q - CNT_ONE);
    end else begin
      case (mode)
        MODE_SAT:     step_val = count_q;
        // Normally the one-shot stops on arrival; reaching here means the
        // count was loaded with the terminal value, so just hold it.
        MODE_ONESHOT: step_val = count_q;
        default:      step_val = start_val;  // wrap and reserved
      endcase
    end

    // Saturate fires tc only on arrival, never while parked at terminal.
    step_tc   = (step_val == term_val) && !(at_term && (mode == MODE_SAT));
    step_done = (mode == MODE_ONESHOT) && (step_val == term_val);
  end

  // Next-state logic: reset > load > start > stop > prescaler/count step.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;

    if (load) begin
      // Load works in any state and leaves the state machine alone.
      count_d = load_val;
      presc_d = '0;
    end else if (start) begin
      // Start from IDLE/DONE, or restart from RUN, behaves identically.
      count_d = start_val;
      presc_d = '0;
      state_d = ST_RUN;
    end else if (stop && (state_q == ST_RUN)) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else if (state_q == ST_RUN) begin
      if (enable) begin
        if (presc_match) begin
          presc_d = '0;
          tick_d  = 1'b1;
          count_d = step_val;
          tc_d    = step_tc;
          if (step_done) begin
            state_d = ST_DONE;
          end
        end else begin
          // If div was lowered below the current prescaler value, this keeps
          // counting and wraps at 2^PW before matching again.
          presc_d = presc_q + PRESC_ONE;
        end
      end
    end else begin
      // IDLE and DONE keep the prescaler parked at zero.
      presc_d = '0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
    end
  end

`ifdef PRESCALED_COUNTER_CAPTURE_EN
  logic [N-1:0] capture_val_q;
  logic         capture_vld_q;

  // Snapshot the pre-step count on a capture strobe; purely observational.
  always_ff @(posedge clk) begin
    if (reset) begin
      capture_val_q <= '0;
      capture_vld_q <= 1'b0;
    end else begin
      capture_vld_q <= capture;
      if (capture) begin
        capture_val_q <= count_q;
      end
    end
  end

  assign capture_val = capture_val_q;
  assign capture_vld = capture_vld_q;
`endif

  // Registered outputs and state decodes.
  assign count   = count_q;
  assign tick    = tick_q;
  assign tc      = tc_q;
  assign running = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Testbench for prescaled_updown_counter (N=8, PW=8).
// Stimulus pushes the hand-computed expected outputs for each clock edge
// into a queue; an independent monitor pops one entry per edge and compares.

module tb_prescaled_updown_counter;

  localparam int N  = 8;
  localparam int PW = 8;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [PW-1:0] div;
  logic [N-1:0]  limit;
  logic          up;
  logic [1:0]    mode;
  logic          start;
  logic          stop;
  logic          load;
  logic [N-1:0]  load_val;
  logic          capture;
  logic [N-1:0]  capture_val;
  logic          capture_vld;
  logic [N-1:0]  count;
  logic          tick;
  logic          tc;
  logic          running;
  logic          done;

  prescaled_updown_counter #(.N(N), .PW(PW)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .div         (div),
    .limit       (limit),
    .up          (up),
    .mode        (mode),
    .start       (start),
    .stop        (stop),
    .load        (load),
    .load_val    (load_val),
`ifdef PRESCALED_COUNTER_CAPTURE_EN
    .capture     (capture),
    .capture_val (capture_val),
    .capture_vld (capture_vld),
`endif
    .count       (count),
    .tick        (tick),
    .tc          (tc),
    .running     (running),
    .done        (done)
  );

`ifndef PRESCALED_COUNTER_CAPTURE_EN
  assign capture_val = '0;
  assign capture_vld = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] cnt;
    logic         tk;
    logic         tcv;
    logic         run;
    logic         dn;
    logic [N-1:0] cval;
    logic         cvld;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] exp_cap_val = '0;
  logic         exp_cap_vld = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Queue the expected outputs for the coming edge, then advance past it.
  task automatic cyc(input string nm, input logic [N-1:0] c, input logic tk,
                     input logic tcv, input logic run, input logic dn);
    exp_t e;
    e.cnt  = c;
    e.tk   = tk;
    e.tcv  = tcv;
    e.run  = run;
    e.dn   = dn;
    e.cval = exp_cap_val;
    e.cvld = exp_cap_vld;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected entry per edge, sampled 1 time unit after it.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, ".count"},   32'(count),   32'(e.cnt));
        check({nm, ".tick"},    32'(tick),    32'(e.tk));
        check({nm, ".tc"},      32'(tc),      32'(e.tcv));
        check({nm, ".running"}, 32'(running), 32'(e.run));
        check({nm, ".done"},    32'(done),    32'(e.dn));
`ifdef PRESCALED_COUNTER_CAPTURE_EN
        check({nm, ".capture_val"}, 32'(capture_val), 32'(e.cval));
        check({nm, ".capture_vld"}, 32'(capture_vld), 32'(e.cvld));
`endif
      end
    end
  end

  initial begin
    logic [N-1:0] prev;
    logic [N-1:0] v;

    reset    = 1'b1;
    enable   = 1'b0;
    div      = '0;
    limit    = '0;
    up       = 1'b1;
    mode     = 2'd0;
    start    = 1'b0;
    stop     = 1'b0;
    load     = 1'b0;
    load_val = '0;
    capture  = 1'b0;

    cyc("reset", 8'h00, 0, 0, 0, 0);

    // Up, wrap, div=3, limit=5: a step every 4 cycles, tc with 5, then 0.
    reset  = 1'b0;
    div    = 8'd3;
    limit  = 8'd5;
    up     = 1'b1;
    mode   = 2'd0;
    enable = 1'b1;
    start  = 1'b1;
    cyc("wrap_start", 8'h00, 0, 0, 1, 0);
    start = 1'b0;
    prev  = 8'h00;
    for (int k = 1; k <= 6; k++) begin
      v = 8'(k % 6);
      repeat (3) cyc("wrap_hold", prev, 0, 0, 1, 0);
      if (k == 5) begin
        capture     = 1'b1;
        exp_cap_val = 8'd4;
        exp_cap_vld = 1'b1;
      end
      cyc("wrap_step", v, 1, (v == 8'd5), 1, 0);
      capture     = 1'b0;
      exp_cap_vld = 1'b0;
      prev = v;
    end

    // Down, one-shot, div=0, limit=3: 3,2,1,0 then DONE.
    div   = 8'd0;
    limit = 8'd3;
    up    = 1'b0;
    mode  = 2'd2;
    start = 1'b1;
    cyc("oneshot_start", 8'd3, 0, 0, 1, 0);
    start = 1'b0;
    cyc("oneshot_2", 8'd2, 1, 0, 1, 0);
    cyc("oneshot_1", 8'd1, 1, 0, 1, 0);
    cyc("oneshot_0", 8'd0, 1, 1, 0, 1);
    repeat (3) cyc("oneshot_done", 8'd0, 0, 0, 0, 1);

    // Up, saturate, div=0, limit=2: tc once at 2, then held.
    limit = 8'd2;
    up    = 1'b1;
    mode  = 2'd1;
    start = 1'b1;
    cyc("sat_start", 8'd0, 0, 0, 1, 0);
    start = 1'b0;
    cyc("sat_1", 8'd1, 1, 0, 1, 0);
    cyc("sat_2", 8'd2, 1, 1, 1, 0);
    repeat (10) cyc("sat_hold", 8'd2, 1, 0, 1, 0);

    // div=1 with enable dropped mid-period: prescaler freezes then resumes.
    div   = 8'd1;
    limit = 8'd5;
    mode  = 2'd0;
    start = 1'b1;
    cyc("en_start", 8'd0, 0, 0, 1, 0);
    start = 1'b0;
    cyc("en_p1", 8'd0, 0, 0, 1, 0);
    cyc("en_step1", 8'd1, 1, 0, 1, 0);
    cyc("en_p1b", 8'd1, 0, 0, 1, 0);
    enable = 1'b0;
    repeat (5) cyc("en_frozen", 8'd1, 0, 0, 1, 0);
    enable = 1'b1;
    cyc("en_step2", 8'd2, 1, 0, 1, 0);
    cyc("en_p1c", 8'd2, 0, 0, 1, 0);
    cyc("en_step3", 8'd3, 1, 0, 1, 0);

    // Load beyond limit in up mode: runs to 0xFF, wraps through 0.
    div      = 8'd0;
    load     = 1'b1;
    load_val = 8'hFE;
    cyc("big_load", 8'hFE, 0, 0, 1, 0);
    load = 1'b0;
    cyc("big_ff", 8'hFF, 1, 0, 1, 0);
    cyc("big_00", 8'h00, 1, 0, 1, 0);
    cyc("big_01", 8'h01, 1, 0, 1, 0);

    // Load beats start and stop; then stop, ignored stop, restart, reset.
    load     = 1'b1;
    load_val = 8'hAA;
    start    = 1'b1;
    stop     = 1'b1;
    cyc("load_prio", 8'hAA, 0, 0, 1, 0);
    load  = 1'b0;
    start = 1'b0;
    cyc("stop", 8'hAA, 0, 0, 0, 0);
    stop = 1'b0;
    repeat (2) cyc("idle_hold", 8'hAA, 0, 0, 0, 0);
    stop = 1'b1;
    cyc("stop_idle", 8'hAA, 0, 0, 0, 0);
    stop  = 1'b0;
    start = 1'b1;
    cyc("restart", 8'd0, 0, 0, 1, 0);
    start = 1'b0;
    cyc("restart_1", 8'd1, 1, 0, 1, 0);
    cyc("restart_2", 8'd2, 1, 0, 1, 0);
    reset       = 1'b1;
    exp_cap_val = '0;
    cyc("reset_mid", 8'd0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc("after_reset", 8'd0, 0, 0, 0, 0);

    // Let the monitor drain the queue, with a bounded wait.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
